// File: rtl/sram_like_resp_pkg.sv
// Shared types for the SRAM-like responder: access sizes, stamp width and
// the layout of one queued response.
package sram_like_resp_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int STAMP_W = 8;

  typedef struct packed {
    logic               wr;
    logic [31:0]        rdata;
    logic [STAMP_W-1:0] stamp;
  } resp_entry_t;

  // Byte-lane merge used for masked writes into a stored word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int lane = 0; lane < 4; lane++) begin
      if (strb[lane]) merged[8*lane +: 8] = new_word[8*lane +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// SRAM-like request/response bus; the initiator (master) also drives the
// stall_addr back-pressure input of the responder.
interface sram_like_resp_if;

  logic                      req;
  logic                      wr;
  sram_like_resp_pkg::size_e size;
  logic [31:0]               addr;
  logic [3:0]                wstrb;
  logic [31:0]               wdata;
  logic                      stall_addr;
  logic                      addr_ok;
  logic                      data_ok;
  logic [31:0]               rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata, stall_addr,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, stall_addr,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_resp_resp_fifo.sv
// In-order synchronous FIFO of pending responses with full/empty flags and
// a combinational view of the head entry.
module resp_fifo
  import sram_like_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  resp_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output resp_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  resp_entry_t      slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like memory responder: accepts requests with addr_ok and answers each
// with a data_ok pulse a fixed number of cycles later, strictly in order.
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2,
  parameter int OUTST   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  sram_like_resp_if.slave   bus
);

  localparam int WORDS = 1 << ADDR_W;
  localparam logic [STAMP_W-1:0] LAT = STAMP_W'(LATENCY);

  logic [31:0]        mem [WORDS];
  logic [STAMP_W-1:0] counter;
  logic               live;
  logic               full;
  logic               empty;
  logic               accept;
  logic               ready;
  logic               pop;
  logic [ADDR_W-1:0]  idx;
  resp_entry_t        head;
  resp_entry_t        new_entry;
  logic               unused_bits;

  assign idx         = bus.addr[ADDR_W+1:2];
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  // live stays low through the reset cycle and the one after it.
  assign bus.addr_ok = bus.req & ~bus.stall_addr & ~full & resetn & live;
  assign accept      = bus.req & bus.addr_ok;

  // Modular stamp distance stays small, so counter wrap is harmless.
  assign ready       = ((counter - head.stamp) >= LAT);
  assign pop         = resetn & ~empty & ready;
  assign bus.data_ok = pop;
  assign bus.rdata   = (pop & ~head.wr) ? head.rdata : 32'h0;

  assign new_entry = '{wr:    bus.wr,
                       rdata: bus.wr ? 32'h0 : mem[idx],
                       stamp: counter};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter <= '0;
      live    <= 1'b0;
    end else begin
      counter <= counter + STAMP_W'(1);
      live    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.wr) mem[idx] <= merge_bytes(mem[idx], bus.wdata, bus.wstrb);
  end

  resp_fifo #(
    .DEPTH(OUTST)
  ) u_resp_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_data(new_entry),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: instance A runs against a queue-based model every
// cycle; B (LATENCY=3) and C (LATENCY=4) cover counter wrap and a full FIFO.
module tb_sram_like_resp;
  import sram_like_resp_pkg::*;

  localparam int ADDR_W_A = 16;
  localparam int LAT_A    = 2;
  localparam int OUTST_A  = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_resp_if bus_a ();
  sram_like_resp_if bus_b ();
  sram_like_resp_if bus_c ();

  sram_like_resp #(.ADDR_W(ADDR_W_A), .LATENCY(LAT_A), .OUTST(OUTST_A))
    dut_a (.clk(clk), .resetn(resetn), .bus(bus_a));
  sram_like_resp #(.ADDR_W(8), .LATENCY(3), .OUTST(4))
    dut_b (.clk(clk), .resetn(resetn), .bus(bus_b));
  sram_like_resp #(.ADDR_W(8), .LATENCY(4), .OUTST(4))
    dut_c (.clk(clk), .resetn(resetn), .bus(bus_c));

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model for A: memory as a sparse word map, pending responses as
  // a queue of (kind, data, due cycle) counted from the last reset.
  typedef struct {
    logic        wr;
    logic [31:0] data;
    bit          known;
    int          due;
  } exp_resp_t;

  exp_resp_t   q[$];
  logic [31:0] mem_m [int];
  int          t = 0;
  bit          first_after = 1'b0;

  always @(negedge clk) begin : model
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rd;
    logic [31:0] w;
    bit          rd_chk;
    int          idx;
    exp_resp_t   e;
    e_aok  = 1'b0;
    e_dok  = 1'b0;
    e_rd   = 32'h0;
    rd_chk = 1'b1;
    if (resetn) begin
      e_aok = bus_a.req && !bus_a.stall_addr && (q.size() < OUTST_A) && !first_after;
      e_dok = (q.size() > 0) && (q[0].due <= t);
      if (e_dok && !q[0].wr) begin
        e_rd   = q[0].data;
        rd_chk = q[0].known;
      end
    end
    checkOutput("A addr_ok", 32'(bus_a.addr_ok), 32'(e_aok));
    checkOutput("A data_ok", 32'(bus_a.data_ok), 32'(e_dok));
    if (rd_chk) checkOutput("A rdata", bus_a.rdata, e_rd);
    if (!resetn) begin
      q.delete();
      first_after = 1'b1;
      t = 0;
    end else begin
      first_after = 1'b0;
      if (e_dok) void'(q.pop_front());
      if (e_aok) begin
        idx     = int'(bus_a.addr[ADDR_W_A+1:2]);
        e.wr    = bus_a.wr;
        e.due   = t + LAT_A;
        e.known = bus_a.wr || mem_m.exists(idx);
        e.data  = (!bus_a.wr && mem_m.exists(idx)) ? mem_m[idx] : 32'h0;
        if (bus_a.wr && (mem_m.exists(idx) || bus_a.wstrb == 4'hF)) begin
          w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus_a.wstrb[b]) w[8*b +: 8] = bus_a.wdata[8*b +: 8];
          mem_m[idx] = w;
        end
        q.push_back(e);
      end
      t++;
    end
  end

  int          acc_cyc;
  int          resp_cyc;
  logic [31:0] resp_data;

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus_a.req = 1'b1; bus_a.wr = w; bus_a.addr = a;
    bus_a.wstrb = s; bus_a.wdata = d; bus_a.size = SZ_WORD;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_a.addr_ok) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    bus_a.req = 1'b0;
    checkOutput("A accepted within bound", 32'(got), 32'd1);
  endtask

  task automatic waitResp(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_a.data_ok) begin
        got = 1'b1;
        resp_cyc = cyc;
        resp_data = bus_a.rdata;
      end
    end
    checkOutput({name, " arrived"}, 32'(got), 32'd1);
  endtask

  logic [15:0] idx_set [8] = '{16'h0000, 16'h0004, 16'h0005, 16'h0100,
                               16'h1234, 16'hFFFF, 16'h0007, 16'h8000};

  initial begin : watchdog
    #1000000;
    n_bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : main
    int          k;
    int          nr;
    int          dcount;
    int          c_acc [5];
    int          c_rcyc [5];
    logic [31:0] c_resp [5];
    bit          got;

    bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = SZ_WORD; bus_a.addr = '0;
    bus_a.wstrb = '0; bus_a.wdata = '0; bus_a.stall_addr = 1'b0;
    bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = SZ_WORD; bus_b.addr = '0;
    bus_b.wstrb = '0; bus_b.wdata = '0; bus_b.stall_addr = 1'b0;
    bus_c.req = 1'b0; bus_c.wr = 1'b0; bus_c.size = SZ_WORD; bus_c.addr = '0;
    bus_c.wstrb = '0; bus_c.wdata = '0; bus_c.stall_addr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_a.req = 1'b1;
    @(negedge clk);
    checkOutput("addr_ok first cycle after reset", 32'(bus_a.addr_ok), 32'd0);
    checkOutput("data_ok after reset", 32'(bus_a.data_ok), 32'd0);
    @(posedge clk); #1;
    bus_a.req = 1'b0;

    applyStimulus(1'b1, 32'h1C000000, 4'hF, 32'hDEADBEEF);
    waitResp("write resp");
    checkOutput("write resp rdata", resp_data, 32'h0);
    applyStimulus(1'b0, 32'h1C000000, 4'hF, 32'h0);
    waitResp("read resp");
    checkOutput("read latency", 32'(resp_cyc - acc_cyc), 32'd2);
    checkOutput("read DEADBEEF", resp_data, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h00000010, 4'hF, 32'h11223344);
    waitResp("write 0x10");
    applyStimulus(1'b1, 32'h00000010, 4'h1, 32'h000000AA);
    waitResp("byte write 0x10");
    applyStimulus(1'b0, 32'h00000010, 4'h0, 32'h0);
    waitResp("read 0x10");
    checkOutput("byte merge", resp_data, 32'h112233AA);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, {14'($urandom), idx_set[i], 2'($urandom)}, 4'hF, $urandom);
      waitResp("init write");
    end

    // Random traffic on A; the model process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus_a.req        = ($urandom_range(0, 9) < 7);
      bus_a.wr         = 1'($urandom_range(0, 1));
      bus_a.stall_addr = ($urandom_range(0, 4) == 0);
      bus_a.addr       = {14'($urandom), idx_set[$urandom_range(0, 7)], 2'($urandom)};
      bus_a.wstrb      = 4'($urandom);
      bus_a.wdata      = $urandom;
      bus_a.size       = size_e'(2'($urandom_range(0, 2)));
    end
    @(posedge clk); #1;
    bus_a.req = 1'b0; bus_a.stall_addr = 1'b0;
    repeat (10) @(posedge clk);

    #1;
    bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 32'h00000020;
    bus_a.wstrb = 4'hF; bus_a.wdata = 32'hCAFEF00D; bus_a.stall_addr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stalled addr_ok %0d", i), 32'(bus_a.addr_ok), 32'd0);
      @(posedge clk); #1;
    end
    bus_a.stall_addr = 1'b0;
    @(negedge clk);
    checkOutput("addr_ok as stall falls", 32'(bus_a.addr_ok), 32'd1);
    @(posedge clk); #1;
    bus_a.req = 1'b0;
    waitResp("stalled write");
    applyStimulus(1'b0, 32'h00000020, 4'h0, 32'h0);
    waitResp("read 0x20");
    checkOutput("read after stall", resp_data, 32'hCAFEF00D);

    // C (LATENCY=4, OUTST=4): load five words, then stream five reads.
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      bus_c.req = 1'b1; bus_c.wr = 1'b1; bus_c.addr = 32'(j * 4);
      bus_c.wstrb = 4'hF; bus_c.wdata = 32'hC0DE0000 + 32'(j);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (bus_c.addr_ok) got = 1'b1;
        @(posedge clk); #1;
      end
      bus_c.req = 1'b0;
      checkOutput("C write accepted", 32'(got), 32'd1);
    end
    repeat (12) @(posedge clk);
    #1;
    k = 0; nr = 0;
    for (int j = 0; j < 5; j++) begin
      c_acc[j] = -1; c_rcyc[j] = -1; c_resp[j] = 32'h0;
    end
    bus_c.req = 1'b1; bus_c.wr = 1'b0; bus_c.addr = 32'h0;
    for (int cy = 0; cy < 16; cy++) begin
      @(negedge clk);
      if (bus_c.data_ok && nr < 5) begin
        c_resp[nr] = bus_c.rdata; c_rcyc[nr] = cy; nr++;
      end
      if (bus_c.addr_ok && k < 5) begin
        c_acc[k] = cy; k++;
      end
      @(posedge clk); #1;
      if (k >= 5) bus_c.req = 1'b0;
      else bus_c.addr = 32'(k * 4);
    end
    bus_c.req = 1'b0;
    checkOutput("C accept count", 32'(k), 32'd5);
    checkOutput("C 4th accept cycle", 32'(c_acc[3]), 32'd3);
    checkOutput("C 5th accept cycle", 32'(c_acc[4]), 32'd5);
    checkOutput("C first data_ok cycle", 32'(c_rcyc[0]), 32'd4);
    checkOutput("C last data_ok cycle", 32'(c_rcyc[4]), 32'd9);
    checkOutput("C response count", 32'(nr), 32'd5);
    for (int j = 0; j < 5; j++)
      checkOutput($sformatf("C rdata order %0d", j), c_resp[j], 32'hC0DE0000 + 32'(j));

    // B (LATENCY=3): accept at counter 254, answer lands at counter 1.
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.addr = 32'h0;
    @(negedge clk);
    checkOutput("B accept at counter 254", 32'(bus_b.addr_ok), 32'd1);
    @(posedge clk); #1;
    bus_b.req = 1'b0;
    for (int off = 1; off <= 4; off++) begin
      @(negedge clk);
      checkOutput($sformatf("B data_ok offset %0d", off), 32'(bus_b.data_ok),
                  (off == 3) ? 32'd1 : 32'd0);
    end

    // A: two reads in flight, then a one-cycle reset drops both.
    @(posedge clk); #1;
    bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h00000014;
    @(negedge clk);
    checkOutput("A read 1 accepted", 32'(bus_a.addr_ok), 32'd1);
    @(posedge clk); #1;
    bus_a.addr = 32'h00000010;
    @(negedge clk);
    checkOutput("A read 2 accepted", 32'(bus_a.addr_ok), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("addr_ok during reset", 32'(bus_a.addr_ok), 32'd0);
    checkOutput("data_ok during reset", 32'(bus_a.data_ok), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("addr_ok cycle after reset", 32'(bus_a.addr_ok), 32'd0);
    @(posedge clk); #1;
    bus_a.req = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_a.data_ok) dcount++;
    end
    checkOutput("no data_ok after reset", 32'(dcount), 32'd0);
    applyStimulus(1'b0, 32'h00000020, 4'h0, 32'h0);
    waitResp("read after reset");
    checkOutput("memory kept over reset", resp_data, 32'hCAFEF00D);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_like_resp.md
SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning word-index width; memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from acceptance to data_ok; legal range 1..15.
REQ-003 SHALL have parameter OUTST, default 4, meaning the maximum number of accepted requests awaiting data_ok (a power of two).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req  input  1  request valid from the initiator.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port size  input  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wstrb  input  4  byte-lane write mask.
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle.
REQ-013 SHALL have port data_ok  output  1  one-cycle response pulse, issued for reads and writes.
REQ-014 SHALL have port rdata  output  32  read data, valid while data_ok=1 for a read.
REQ-015 SHALL have port stall_addr  input  1  bench-driven back-pressure; forces addr_ok=0.

Function
REQ-016 SHALL drive addr_ok = req & ~stall_addr & ~full combinationally; the request is accepted on a cycle where req & addr_ok.
REQ-017 SHALL index memory with addr[ADDR_W+1:2]; addr[31:ADDR_W+2] and addr[1:0] SHALL be ignored.
REQ-018 SHALL, on an accepted write, update only the bytes enabled in wstrb at the clock edge; size is informational only.
REQ-019 SHALL, on an accepted read, capture the full word at acceptance, so an earlier accepted write to the same word is visible.
REQ-020 SHALL push one entry {wr, captured rdata, stamp} per acceptance into an in-order response FIFO of depth OUTST.
REQ-021 SHALL keep an 8-bit free-running cycle counter; stamp = counter value at acceptance.
REQ-022 SHALL assert data_ok when the FIFO is not empty and ((counter - head.stamp) mod 256) >= LATENCY, then pop the head.
REQ-023 SHALL issue responses strictly in acceptance order, at most one per cycle.
REQ-024 SHALL drive rdata = head.rdata when data_ok is asserted for a read, and 0 otherwise, including write responses.
REQ-025 SHALL produce the earliest data_ok exactly LATENCY cycles after the acceptance edge.
REQ-026 SHALL NOT accept a request when full, even if a pop occurs in the same cycle.
REQ-027 SHALL permit a push and a pop in the same cycle when not full; the occupancy count is then unchanged.
REQ-028 SHALL compute correct ready times across wrap of the 8-bit counter, since the modular difference stays below 16.
REQ-029 SHALL ignore req while resetn=0.
REQ-030 SHALL provide no cancellation; the initiator discards unwanted responses.

Reset
REQ-031 SHALL, on the resetn=0 edge, clear the FIFO pointers and occupancy, the counter, data_ok and rdata.
REQ-032 SHALL, on reset mid-operation, drop all pending responses; no data_ok SHALL follow for requests accepted before reset.
REQ-033 SHALL NOT clear memory contents on reset.
REQ-034 SHALL drive addr_ok=0 and data_ok=0 during reset and in the first cycle after it.

Structure
REQ-035 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the stamp width (8) and the FIFO entry layout from the shared package.
REQ-036 SHALL instantiate one sub-module, resp_fifo, a parameterized synchronous FIFO with full, empty and head outputs.
REQ-037 SHALL keep the memory array, the counter and the ready compare in the top module.

Verification
REQ-038 SHALL cover: write word 0x1C000000 = 0xDEADBEEF with wstrb 0xF, then read 0x1C000000 -> read data_ok arrives 2 cycles after its addr_ok, rdata = 0xDEADBEEF.
REQ-039 SHALL cover: write 0x000000AA to 0x10 with wstrb 0x1 over stored 0x11223344 -> a read of 0x10 returns 0x112233AA.
REQ-040 SHALL cover: 5 back-to-back reads with req held at 1 and OUTST=4 -> addr_ok drops on the 5th until the first data_ok; data returns in order.
REQ-041 SHALL cover: stall_addr=1 for 3 cycles with req=1 -> addr_ok=0 and no memory change; the request is accepted on the cycle stall_addr falls.
REQ-042 SHALL cover: accept a read at counter=254 with LATENCY=3 -> data_ok when counter=1.
REQ-043 SHALL cover: 2 reads outstanding, then resetn=0 for 1 cycle -> no data_ok afterwards, addr_ok=0 in the cycle after reset.
